// File: rtl/i2cmb_pkg.sv
// Shared encodings for the iicmb Wishbone sequencer: register map, byte-level
// commands, CMDR status bits, completion codes and sequencer states.
package i2cmb_pkg;

    typedef enum logic [1:0] {
        REG_CSR  = 2'd0,
        REG_DPR  = 2'd1,
        REG_CMDR = 2'd2
    } reg_addr_e;

    typedef enum logic [2:0] {
        CMD_WRITE    = 3'b001,
        CMD_READ_ACK = 3'b010,
        CMD_READ_NAK = 3'b011,
        CMD_START    = 3'b100,
        CMD_STOP     = 3'b101,
        CMD_SET_BUS  = 3'b110
    } cmd_e;

    localparam logic [7:0] CSR_ENABLE = 8'hC0;

    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_AL  = 5;
    localparam int CMDR_ERR = 4;

    typedef enum logic [2:0] {
        ST_OK       = 3'd0,
        ST_ADDR_NAK = 3'd1,
        ST_DATA_NAK = 3'd2,
        ST_ARB_LOST = 3'd3,
        ST_CORE_ERR = 3'd4,
        ST_TIMEOUT  = 3'd5,
        ST_BAD_LEN  = 3'd6
    } status_e;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_DPR, S_CMD, S_IRQ, S_CMD_RD, S_WDATA, S_RD_DPR, S_DONE
    } state_e;

    typedef enum logic [2:0] {
        STEP_SEL, STEP_START, STEP_ADDR, STEP_WRITE, STEP_READ, STEP_STOP
    } step_e;

    // The final byte of a read is NAKed so the slave releases SDA before STOP.
    function automatic cmd_e read_cmd(input logic last);
        return last ? CMD_READ_NAK : CMD_READ_ACK;
    endfunction

endpackage

// File: rtl/i2cmb_wb_access.sv
// Single-access Wishbone master: one request in, one done pulse out; bus
// signals held stable until ack, then released on the following cycle.
module i2cmb_wb_access #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          acc_req,
    input  logic          acc_we,
    input  logic [AW-1:0] acc_adr,
    input  logic [DW-1:0] acc_wdat,
    output logic          acc_done,
    output logic [DW-1:0] acc_rdata,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic [DW-1:0] dat_i,
    input  logic          ack_i
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_done  <= 1'b0;
            acc_rdata <= '0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
        end else begin
            acc_done <= 1'b0;
            if (cyc_o) begin
                if (ack_i) begin
                    cyc_o    <= 1'b0;
                    stb_o    <= 1'b0;
                    acc_done <= 1'b1;
                    if (!we_o)
                        acc_rdata <= dat_i;
                end
            end else if (acc_req) begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= acc_we;
                adr_o <= acc_adr;
                dat_o <= acc_wdat;
            end
        end
    end

endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// Hardware sequencer for the iicmb_m_wb controller: turns one I2C transaction
// request into the CSR/DPR/CMDR access stream, waiting on irq per command.
module i2cmb_wb_sequencer
    import i2cmb_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8,
    parameter int LEN_WIDTH     = 8,
    parameter int IRQ_TIMEOUT   = 100000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [3:0]               req_bus,
    input  logic [6:0]               req_addr,
    input  logic [LEN_WIDTH-1:0]     req_len,
    input  logic                     wdata_valid,
    input  logic [7:0]               wdata,
    output logic                     wdata_ready,
    output logic                     rdata_valid,
    output logic [7:0]               rdata,
    output logic                     done,
    output logic [2:0]               status,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int TW = $clog2(IRQ_TIMEOUT + 1);

    state_e                   state;
    step_e                    step;
    cmd_e                     cmd;
    status_e                  res;
    logic                     pend;
    logic                     acc_req;
    logic                     acc_we;
    logic [WB_ADDR_WIDTH-1:0] acc_adr;
    logic [WB_DATA_WIDTH-1:0] acc_wdat;
    logic                     acc_done;
    logic [WB_DATA_WIDTH-1:0] acc_rdata;
    logic [7:0]               dpr_data;
    logic                     r_rw;
    logic [3:0]               r_bus;
    logic [6:0]               r_addr;
    logic [LEN_WIDTH-1:0]     cnt;
    logic [3:0]               bus_cache;
    logic                     bus_valid;
    logic                     err_stop;
    logic [TW-1:0]            tmo;

    i2cmb_wb_access #(.AW(WB_ADDR_WIDTH), .DW(WB_DATA_WIDTH)) u_acc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .acc_req   (acc_req),
        .acc_we    (acc_we),
        .acc_adr   (acc_adr),
        .acc_wdat  (acc_wdat),
        .acc_done  (acc_done),
        .acc_rdata (acc_rdata),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_INIT;
            step        <= STEP_SEL;
            cmd         <= CMD_STOP;
            res         <= ST_OK;
            pend        <= 1'b0;
            acc_req     <= 1'b0;
            acc_we      <= 1'b0;
            acc_adr     <= '0;
            acc_wdat    <= '0;
            dpr_data    <= '0;
            r_rw        <= 1'b0;
            r_bus       <= '0;
            r_addr      <= '0;
            cnt         <= '0;
            bus_cache   <= '0;
            bus_valid   <= 1'b0;
            err_stop    <= 1'b0;
            tmo         <= '0;
            req_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            done        <= 1'b0;
            status      <= '0;
        end else begin
            acc_req     <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;

            case (state)
                S_INIT: begin
                    if (!pend) begin
                        acc_req  <= 1'b1;
                        pend     <= 1'b1;
                        acc_we   <= 1'b1;
                        acc_adr  <= WB_ADDR_WIDTH'(REG_CSR);
                        acc_wdat <= WB_DATA_WIDTH'(CSR_ENABLE);
                    end else if (acc_done) begin
                        pend      <= 1'b0;
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        r_rw      <= req_rw;
                        r_bus     <= req_bus;
                        r_addr    <= req_addr;
                        cnt       <= req_len;
                        err_stop  <= 1'b0;
                        res       <= ST_OK;
                        if (req_rw && req_len == '0) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            status <= ST_BAD_LEN;
                        end else if (!bus_valid || bus_cache != req_bus) begin
                            step     <= STEP_SEL;
                            cmd      <= CMD_SET_BUS;
                            dpr_data <= {4'b0, req_bus};
                            state    <= S_DPR;
                        end else begin
                            step  <= STEP_START;
                            cmd   <= CMD_START;
                            state <= S_CMD;
                        end
                    end
                end

                S_DPR: begin
                    if (!pend) begin
                        acc_req  <= 1'b1;
                        pend     <= 1'b1;
                        acc_we   <= 1'b1;
                        acc_adr  <= WB_ADDR_WIDTH'(REG_DPR);
                        acc_wdat <= WB_DATA_WIDTH'(dpr_data);
                    end else if (acc_done) begin
                        pend  <= 1'b0;
                        state <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (!pend) begin
                        acc_req  <= 1'b1;
                        pend     <= 1'b1;
                        acc_we   <= 1'b1;
                        acc_adr  <= WB_ADDR_WIDTH'(REG_CMDR);
                        acc_wdat <= WB_DATA_WIDTH'(cmd);
                    end else if (acc_done) begin
                        // irq is only looked at from here on, so a level left
                        // over from before this write can never be mistaken.
                        pend  <= 1'b0;
                        tmo   <= '0;
                        state <= S_IRQ;
                    end
                end

                S_IRQ: begin
                    if (irq_i) begin
                        state <= S_CMD_RD;
                    end else if (tmo == TW'(IRQ_TIMEOUT - 1)) begin
                        if (err_stop || step == STEP_STOP) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            status <= err_stop ? res : ST_TIMEOUT;
                        end else begin
                            res      <= ST_TIMEOUT;
                            err_stop <= 1'b1;
                            step     <= STEP_STOP;
                            cmd      <= CMD_STOP;
                            state    <= S_CMD;
                        end
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                S_CMD_RD: begin
                    if (!pend) begin
                        acc_req <= 1'b1;
                        pend    <= 1'b1;
                        acc_we  <= 1'b0;
                        acc_adr <= WB_ADDR_WIDTH'(REG_CMDR);
                    end else if (acc_done) begin
                        pend <= 1'b0;
                        if (err_stop) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            status <= res;
                        end else if (acc_rdata[CMDR_DON]) begin
                            case (step)
                                STEP_SEL: begin
                                    bus_cache <= r_bus;
                                    bus_valid <= 1'b1;
                                    step      <= STEP_START;
                                    cmd       <= CMD_START;
                                    state     <= S_CMD;
                                end
                                STEP_START: begin
                                    step     <= STEP_ADDR;
                                    cmd      <= CMD_WRITE;
                                    dpr_data <= {r_addr, r_rw};
                                    state    <= S_DPR;
                                end
                                STEP_ADDR, STEP_WRITE: begin
                                    if (r_rw) begin
                                        step  <= STEP_READ;
                                        cmd   <= read_cmd(cnt == LEN_WIDTH'(1));
                                        state <= S_CMD;
                                    end else if (cnt == '0) begin
                                        step  <= STEP_STOP;
                                        cmd   <= CMD_STOP;
                                        state <= S_CMD;
                                    end else begin
                                        state <= S_WDATA;
                                    end
                                end
                                STEP_READ: state <= S_RD_DPR;
                                STEP_STOP: begin
                                    state  <= S_DONE;
                                    done   <= 1'b1;
                                    status <= res;
                                end
                                default: begin
                                    state  <= S_DONE;
                                    done   <= 1'b1;
                                    status <= ST_CORE_ERR;
                                end
                            endcase
                        end else if (acc_rdata[CMDR_NAK]) begin
                            if (step == STEP_STOP) begin
                                state  <= S_DONE;
                                done   <= 1'b1;
                                status <= ST_DATA_NAK;
                            end else begin
                                res      <= (step == STEP_ADDR) ? ST_ADDR_NAK : ST_DATA_NAK;
                                err_stop <= 1'b1;
                                step     <= STEP_STOP;
                                cmd      <= CMD_STOP;
                                state    <= S_CMD;
                            end
                        end else begin
                            // Lost arbitration or core error: the bus is no
                            // longer ours, so STOP is skipped and the cached
                            // selection cannot be trusted.
                            bus_valid <= 1'b0;
                            state     <= S_DONE;
                            done      <= 1'b1;
                            status    <= acc_rdata[CMDR_AL] ? ST_ARB_LOST : ST_CORE_ERR;
                        end
                    end
                end

                S_WDATA: begin
                    if (wdata_ready) begin
                        dpr_data <= wdata;
                        cnt      <= cnt - 1'b1;
                        step     <= STEP_WRITE;
                        cmd      <= CMD_WRITE;
                        state    <= S_DPR;
                    end else if (wdata_valid) begin
                        wdata_ready <= 1'b1;
                    end
                end

                S_RD_DPR: begin
                    if (!pend) begin
                        acc_req <= 1'b1;
                        pend    <= 1'b1;
                        acc_we  <= 1'b0;
                        acc_adr <= WB_ADDR_WIDTH'(REG_DPR);
                    end else if (acc_done) begin
                        pend        <= 1'b0;
                        rdata_valid <= 1'b1;
                        rdata       <= acc_rdata[7:0];
                        cnt         <= cnt - 1'b1;
                        if (cnt == LEN_WIDTH'(1)) begin
                            step  <= STEP_STOP;
                            cmd   <= CMD_STOP;
                            state <= S_CMD;
                        end else begin
                            cmd   <= read_cmd(cnt == LEN_WIDTH'(2));
                            state <= S_CMD;
                        end
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end

                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Scoreboard bench: directed transactions push expected Wishbone accesses,
// read bytes and completion codes; monitors pop and compare as the DUT emits.
module tb_i2cmb_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [3:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_len = '0;
    logic       wdata_valid = 1'b0, wdata_ready;
    logic [7:0] wdata = '0;
    logic       rdata_valid, done;
    logic [7:0] rdata;
    logic [2:0] status;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack, irq;

    always #5 clk = ~clk;

    i2cmb_wb_sequencer #(.IRQ_TIMEOUT(300)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_bus(req_bus), .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .status(status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
    );

    typedef struct packed {
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
    } wb_t;

    wb_t        exp_wb[$];
    logic [2:0] exp_st[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd_src[$];
    logic [7:0] rx[$];
    int         n_vec = 0, n_err = 0, done_cnt = 0;
    logic       hang = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- slave BFM: iicmb register model ----------------
    logic [7:0] csr = '0, dpr = '0, cmdr = '0;
    int         irq_dly;
    logic       exp_addr;

    always @(posedge clk) begin
        if (rst) begin
            ack      <= 1'b0;
            irq      <= 1'b0;
            irq_dly  <= 0;
            exp_addr <= 1'b0;
            dat_i    <= '0;
        end else begin
            if (irq_dly > 1) irq_dly <= irq_dly - 1;
            else if (irq_dly == 1) begin irq <= 1'b1; irq_dly <= 0; end
            if (cyc_o && stb_o && !ack) begin
                ack <= 1'b1;
                if (we_o) begin
                    case (adr_o)
                        2'd0: csr <= dat_o;
                        2'd1: dpr <= dat_o;
                        2'd2: begin
                            cmdr <= 8'h80;
                            case (dat_o[2:0])
                                3'b100: begin exp_addr <= 1'b1; if (!hang) irq_dly <= 4; end
                                3'b001: begin
                                    irq_dly <= 4;
                                    if (exp_addr) begin
                                        exp_addr <= 1'b0;
                                        if (dpr[7:1] == 7'h7F) cmdr <= 8'h40;
                                    end else rx.push_back(dpr);
                                end
                                3'b010, 3'b011: begin
                                    irq_dly <= 4;
                                    if (rd_src.size() > 0) dpr <= rd_src.pop_front();
                                    else dpr <= 8'hEE;
                                end
                                3'b101: begin exp_addr <= 1'b0; irq_dly <= 4; end
                                default: irq_dly <= 4;
                            endcase
                        end
                        default: ;
                    endcase
                end else begin
                    case (adr_o)
                        2'd0: dat_i <= csr;
                        2'd1: dat_i <= dpr;
                        2'd2: begin dat_i <= cmdr; irq <= 1'b0; end
                        default: dat_i <= 8'h00;
                    endcase
                end
            end else begin
                ack <= 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    wb_t mon_a, mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (cyc_o && stb_o && ack) begin
                mon_a = '{we: we_o, adr: adr_o, dat: we_o ? dat_o : 8'h00};
                if (exp_wb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wb_extra: got access 0x%0h, expected none", mon_a);
                end else begin
                    mon_e = exp_wb.pop_front();
                    chk("wb_access", mon_a, mon_e);
                end
            end
            if (rdata_valid) begin
                if (exp_rd.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rdata_extra: got 0x%0h, expected none", rdata);
                end else chk("rdata", rdata, exp_rd.pop_front());
            end
            if (done) begin
                if (exp_st.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL done_extra: got status %0d, expected no done", status);
                end else chk("status", status, exp_st.pop_front());
                chk("wb_left_at_done", exp_wb.size(), 0);
                done_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_w(input logic [1:0] a, input logic [7:0] d);
        exp_wb.push_back('{we: 1'b1, adr: a, dat: d});
    endtask

    task automatic push_r(input logic [1:0] a);
        exp_wb.push_back('{we: 1'b0, adr: a, dat: 8'h00});
    endtask

    task automatic push_cmd(input logic [2:0] c);
        push_w(2'd2, {5'b0, c});
        push_r(2'd2);
    endtask

    // mode: 0 normal, 1 address NAK, 2 no irq after START
    task automatic build_exp(input logic rw, input logic [3:0] bus, input logic [6:0] addr,
                             input int len, input logic sel, input int mode,
                             input logic [2:0] st, input logic [7:0] base);
        exp_st.push_back(st);
        if (rw && len == 0) return;
        if (sel) begin push_w(2'd1, {4'b0, bus}); push_cmd(3'b110); end
        if (mode == 2) begin push_w(2'd2, 8'h04); push_cmd(3'b101); return; end
        push_cmd(3'b100);
        push_w(2'd1, {addr, rw});
        push_cmd(3'b001);
        if (mode == 1) begin push_cmd(3'b101); return; end
        for (int i = 0; i < len; i++) begin
            if (rw) begin
                push_cmd(i == len - 1 ? 3'b011 : 3'b010);
                push_r(2'd1);
                rd_src.push_back(base + 8'(i));
                exp_rd.push_back(base + 8'(i));
            end else begin
                push_w(2'd1, base + 8'(i));
                push_cmd(3'b001);
            end
        end
        push_cmd(3'b101);
    endtask

    task automatic issue_req(input string name, input logic rw, input logic [3:0] bus,
                             input logic [6:0] addr, input int len);
        int c;
        @(negedge clk);
        req_rw = rw; req_bus = bus; req_addr = addr; req_len = 8'(len);
        req_valid = 1'b1;
        for (c = 0; c < 2000; c++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        chk({name, "_accept"}, req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic txn(input string name, input logic rw, input logic [3:0] bus,
                       input logic [6:0] addr, input int len, input logic sel,
                       input int mode, input int stall, input logic [2:0] st,
                       input logic [7:0] base);
        int tgt, lat, busy, c;
        tgt = done_cnt + 1;
        rx.delete();
        build_exp(rw, bus, addr, len, sel, mode, st, base);
        issue_req(name, rw, bus, addr, len);
        if (rw && len == 0) begin
            lat = 0;
            while (done_cnt < tgt && lat < 10) begin @(negedge clk); lat++; end
            chk({name, "_latency_le2"}, lat <= 2, 1);
        end
        if (!rw && mode == 0) begin
            for (int k = 0; k < len; k++) begin
                for (c = 0; c < 3000; c++) begin
                    if (exp_wb.size() == 3 * (len - k) + 2) break;
                    @(negedge clk);
                end
                @(negedge clk);
                busy = 0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    if (cyc_o) busy++;
                end
                if (stall > 0) chk({name, "_stall_idle"}, busy, 0);
                wdata = base + 8'(k);
                wdata_valid = 1'b1;
                for (c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    if (wdata_ready) break;
                end
                chk({name, "_wready"}, wdata_ready, 1);
                @(posedge clk);
                #1 wdata_valid = 1'b0;
            end
        end
        for (c = 0; c < 5000 && done_cnt < tgt; c++) @(negedge clk);
        chk({name, "_done_seen"}, done_cnt, tgt);
        if (!rw && mode == 0) begin
            chk({name, "_rx_count"}, rx.size(), len);
            for (int i = 0; i < rx.size(); i++)
                chk({name, "_rx_byte"}, rx[i], base + 8'(i));
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wdata_ready,
                   rdata_valid, rdata, done, status}, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_outputs");
        push_w(2'd0, 8'hC0);
        @(posedge clk);
        #1 rst = 1'b0;

        txn("wr8_bus0",   1'b0, 4'd0, 7'h22, 8, 1'b1, 0, 0,  3'd0, 8'h00);
        txn("rd8_bus0",   1'b1, 4'd0, 7'h22, 8, 1'b0, 0, 0,  3'd0, 8'h08);
        txn("wr1_bus5",   1'b0, 4'd5, 7'h22, 1, 1'b1, 0, 0,  3'd0, 8'hA5);
        txn("addr_nak",   1'b0, 4'd5, 7'h7F, 2, 1'b0, 1, 0,  3'd1, 8'h00);
        txn("wr3_stall",  1'b0, 4'd5, 7'h22, 3, 1'b0, 0, 50, 3'd0, 8'h11);
        txn("rd_len0",    1'b1, 4'd5, 7'h22, 0, 1'b0, 0, 0,  3'd6, 8'h00);
        txn("wr_probe",   1'b0, 4'd5, 7'h22, 0, 1'b0, 0, 0,  3'd0, 8'h00);
        hang = 1'b1;
        txn("irq_timeout", 1'b0, 4'd5, 7'h22, 1, 1'b0, 2, 0, 3'd5, 8'h00);
        hang = 1'b0;

        // reset in the middle of a read: no done, everything flushed
        build_exp(1'b1, 4'd5, 7'h22, 8, 1'b0, 0, 3'd0, 8'h30);
        issue_req("rd_reset", 1'b1, 4'd5, 7'h22, 8);
        for (c = 0; c < 3000; c++) begin
            if (exp_wb.size() < 15) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        exp_wb.delete(); exp_rd.delete(); exp_st.delete(); rd_src.delete();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_mid_read");
        push_w(2'd0, 8'hC0);
        @(posedge clk);
        #1 rst = 1'b0;

        // bus cache was invalidated by reset, so SET_BUS comes back
        txn("after_reset", 1'b0, 4'd5, 7'h22, 1, 1'b1, 0, 0, 3'd0, 8'h5A);

        repeat (5) @(negedge clk);
        chk("wb_drain", exp_wb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
